// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: table size defaults and the
// 2-bit saturating counter encoding.
package branch_predictor_pkg;

   localparam int BP_ENTRIES_DEF = 16;
   localparam int BP_IDXW_DEF    = $clog2(BP_ENTRIES_DEF);

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } bp_ctr_e;

   // Freshly allocated branches start weakly taken.
   localparam bp_ctr_e CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state: count up on taken, down on not-taken,
// holding at the ends.
module bp_sat_counter
   import branch_predictor_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// mispredict detection / redirect, and resolved-branch statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = BP_ENTRIES_DEF,
   parameter int IDXW    = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_is_branch,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] branch_cnt,
   output logic [31:0] miss_cnt
);

   localparam int TAGW = 30 - IDXW;

   logic            valid_q  [ENTRIES];
   logic            valid_d  [ENTRIES];
   logic [TAGW-1:0] tag_q    [ENTRIES];
   logic [TAGW-1:0] tag_d    [ENTRIES];
   logic [31:0]     target_q [ENTRIES];
   logic [31:0]     target_d [ENTRIES];
   logic [1:0]      ctr_q    [ENTRIES];
   logic [1:0]      ctr_d    [ENTRIES];

   logic [31:0]     branch_cnt_q, branch_cnt_d;
   logic [31:0]     miss_cnt_q, miss_cnt_d;

   logic [IDXW-1:0] if_idx, ex_idx;
   logic [TAGW-1:0] if_tag, ex_tag;
   logic            if_hit, ex_hit;
   logic [1:0]      ctr_upd;

   assign if_idx = if_pc[IDXW+1:2];
   assign if_tag = if_pc[31:IDXW+2];
   assign ex_idx = ex_pc[IDXW+1:2];
   assign ex_tag = ex_pc[31:IDXW+2];

   // Prediction reads registered contents only, so a same-cycle update is
   // visible one cycle later.
   assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign pred_taken  = if_hit && ctr_q[if_idx][1];
   assign pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;

   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   bp_sat_counter u_sat_counter (
      .ctr_i   (ctr_q[ex_idx]),
      .taken_i (ex_taken),
      .ctr_o   (ctr_upd)
   );

   always_comb begin
      mispredict = 1'b0;
      if (ex_valid) begin
         if (ex_is_branch) begin
            mispredict = (ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_pred_target != ex_target));
         end else begin
            mispredict = ex_pred_taken;
         end
      end
   end

   assign redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;

   always_comb begin
      valid_d      = valid_q;
      tag_d        = tag_q;
      target_d     = target_q;
      ctr_d        = ctr_q;
      branch_cnt_d = branch_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (ex_valid) begin
         if (ex_is_branch) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (ex_hit) begin
               ctr_d[ex_idx] = ctr_upd;
               if (ex_taken) target_d[ex_idx] = ex_target;
            end else if (ex_taken) begin
               valid_d[ex_idx]  = 1'b1;
               tag_d[ex_idx]    = ex_tag;
               target_d[ex_idx] = ex_target;
               ctr_d[ex_idx]    = CTR_ALLOC;
            end
         end else if (ex_pred_taken) begin
            // A non-branch was steered by whatever entry shares its index:
            // that entry is an alias, drop it regardless of tag.
            valid_d[ex_idx] = 1'b0;
         end
      end
      if (mispredict) miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_SNT;
         end
         branch_cnt_q <= 32'd0;
         miss_cnt_q   <= 32'd0;
      end else begin
         valid_q      <= valid_d;
         ctr_q        <= ctr_d;
         branch_cnt_q <= branch_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   // Tag and target carry no reset; they are meaningless while valid is 0.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tag_q    <= tag_d;
         target_q <= target_d;
      end
   end

   assign branch_cnt = branch_cnt_q;
   assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations, then randomized traffic against a behavioural table model.
module tb_branch_predictor;

   logic        clk;
   logic        reset;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_is_branch;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] branch_cnt;
   logic [31:0] miss_cnt;

   branch_predictor dut (
      .clk            (clk),
      .reset          (reset),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_is_branch   (ex_is_branch),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .branch_cnt     (branch_cnt),
      .miss_cnt       (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int N = 16;

   // Behavioural model: entries as plain records, counter as an integer 0..3.
   bit          m_valid  [N];
   int unsigned m_tag    [N];
   logic [31:0] m_tgt    [N];
   int          m_ctr    [N];
   int unsigned m_bcnt, m_mcnt;
   bit          m_init;

   int unsigned n_checks, n_pass;

   function automatic int m_index(input logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic int unsigned m_tagof(input logic [31:0] pc);
      return pc / (N * 4);
   endfunction

   function automatic void m_predict(input logic [31:0] pc, output bit pt, output logic [31:0] tgt);
      int i;
      i   = m_index(pc);
      pt  = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
      tgt = pt ? m_tgt[i] : pc + 32'd4;
   endfunction

   function automatic bit m_mispredict();
      if (!ex_valid) return 1'b0;
      if (!ex_is_branch) return ex_pred_taken;
      if (ex_taken != ex_pred_taken) return 1'b1;
      return ex_taken && (ex_pred_target != ex_target);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic compare_model();
      bit          pt;
      logic [31:0] tgt;
      bit          mp;
      m_predict(if_pc, pt, tgt);
      mp = m_mispredict();
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, pt});
      chk("pred_target", pred_target, tgt);
      chk("mispredict", {31'd0, mispredict}, {31'd0, mp});
      if (mp) chk("redirect_pc", redirect_pc, (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4);
      chk("branch_cnt", branch_cnt, m_bcnt);
      chk("miss_cnt", miss_cnt, m_mcnt);
   endtask

   // Drive one cycle's inputs at the falling edge and check settled outputs.
   task automatic drive(input logic rst, input logic [31:0] ipc, input logic v,
                        input logic [31:0] epc, input logic br, input logic tk,
                        input logic [31:0] etgt, input logic ept, input logic [31:0] eptgt);
      @(negedge clk);
      reset = rst; if_pc = ipc; ex_valid = v; ex_pc = epc; ex_is_branch = br;
      ex_taken = tk; ex_target = etgt; ex_pred_taken = ept; ex_pred_target = eptgt;
      #1;
      if (m_init) compare_model();
   endtask

   task automatic tick();
      int i;
      bit mp;
      mp = m_mispredict();
      @(posedge clk);
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0;
            m_ctr[k]   = 0;
         end
         m_bcnt = 0;
         m_mcnt = 0;
         m_init = 1'b1;
      end else if (ex_valid) begin
         i = m_index(ex_pc);
         if (mp) m_mcnt++;
         if (ex_is_branch) begin
            m_bcnt++;
            if (m_valid[i] && m_tag[i] == m_tagof(ex_pc)) begin
               m_ctr[i] = ex_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                   : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
               if (ex_taken) m_tgt[i] = ex_target;
            end else if (ex_taken) begin
               m_valid[i] = 1'b1;
               m_tag[i]   = m_tagof(ex_pc);
               m_tgt[i]   = ex_target;
               m_ctr[i]   = 2;
            end
         end else if (ex_pred_taken) begin
            m_valid[i] = 1'b0;
         end
      end
   endtask

   localparam logic [31:0] PC_A  = 32'h0040_0010;
   localparam logic [31:0] PC_AL = 32'h0040_0050;
   localparam logic [31:0] TG_A  = 32'h0040_0040;

   initial begin
      bit          pt;
      logic [31:0] tgt;
      logic [31:0] rpc;
      n_checks = 0; n_pass = 0; m_init = 1'b0; m_bcnt = 0; m_mcnt = 0;
      reset = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_is_branch = 1'b0;
      ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;

      drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0); tick();

      drive(0, PC_A, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_reset_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("lit_reset_pred_target", pred_target, 32'h0040_0014);
      chk("lit_reset_branch_cnt", branch_cnt, 32'd0);
      chk("lit_reset_miss_cnt", miss_cnt, 32'd0);
      tick();

      // Allocate while fetching the same index: fetch sees the old (empty) entry.
      drive(0, PC_A, 1, PC_A, 1, 1, TG_A, 0, 32'h0);
      chk("lit_alloc_mispredict", {31'd0, mispredict}, 32'd1);
      chk("lit_alloc_redirect", redirect_pc, TG_A);
      chk("lit_same_cycle_old", {31'd0, pred_taken}, 32'd0);
      tick();

      drive(0, PC_A, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("lit_alloc_pred_target", pred_target, TG_A);
      tick();

      drive(0, PC_A, 1, PC_A, 1, 0, TG_A, 1, TG_A);
      chk("lit_nt1_mispredict", {31'd0, mispredict}, 32'd1);
      chk("lit_nt1_redirect", redirect_pc, 32'h0040_0014);
      tick();

      drive(0, PC_A, 1, PC_A, 1, 0, TG_A, 0, 32'h0040_0014);
      chk("lit_wnt_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("lit_nt2_mispredict", {31'd0, mispredict}, 32'd0);
      tick();

      drive(0, PC_A, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_snt_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("lit_cnt_branch", branch_cnt, 32'd3);
      chk("lit_cnt_miss", miss_cnt, 32'd2);
      tick();

      // Train back up to taken (00 -> 01 -> 10).
      drive(0, PC_A, 1, PC_A, 1, 1, TG_A, 0, 32'h0); tick();
      drive(0, PC_A, 1, PC_A, 1, 1, TG_A, 0, 32'h0); tick();
      drive(0, PC_A, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_retrain_pred_taken", {31'd0, pred_taken}, 32'd1);
      tick();

      drive(0, PC_A, 1, PC_AL, 0, 0, 0, 1, TG_A);
      chk("lit_alias_mispredict", {31'd0, mispredict}, 32'd1);
      chk("lit_alias_redirect", redirect_pc, 32'h0040_0054);
      tick();

      drive(0, PC_A, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_alias_invalidated", {31'd0, pred_taken}, 32'd0);
      tick();

      // Taken branch resolving under reset must leave no trace.
      drive(1, 32'h0040_0020, 1, 32'h0040_0020, 1, 1, 32'h0040_0080, 0, 0); tick();
      drive(0, 32'h0040_0020, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_rst_upd_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("lit_rst_upd_branch_cnt", branch_cnt, 32'd0);
      chk("lit_rst_upd_miss_cnt", miss_cnt, 32'd0);
      tick();

      for (int c = 0; c < 600; c++) begin
         logic [31:0] ipc, epc, etgt, eptgt;
         logic        rst, v, br, tk, ept;
         rst  = ($urandom_range(0, 63) == 0);
         ipc  = 32'h0040_0000 + ({26'd0, 6'($urandom_range(0, 63))} << 2);
         epc  = 32'h0040_0000 + ({26'd0, 6'($urandom_range(0, 63))} << 2);
         etgt = 32'h0040_1000 + ({28'd0, 4'($urandom_range(0, 7))} << 4);
         v    = ($urandom_range(0, 3) != 0);
         br   = ($urandom_range(0, 4) != 0);
         tk   = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 1) == 1) begin
            m_predict(epc, pt, tgt);
            ept = pt; eptgt = tgt;
         end else begin
            ept = $urandom_range(0, 1) == 1;
            eptgt = ($urandom_range(0, 1) == 1) ? etgt : epc + 32'd4;
         end
         if (c == 300) epc = 32'hFFFF_FFFC;
         drive(rst, ipc, v, epc, br, tk, etgt, ept, eptgt);
         tick();
      end

      // Wrap of ex_pc+4 through the top of the address space.
      drive(0, 32'h0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0, 1, 32'h10);
      rpc = redirect_pc;
      chk("lit_wrap_redirect", rpc, 32'h0000_0000);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning number of direct-mapped table entries (power of 2, 4..64).
REQ-002 SHALL have parameter IDXW, default log2(ENTRIES), meaning index width taken from PC[IDXW+1:2].
REQ-003 SHALL have port clk, input, 1, meaning single system clock, rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port if_pc, input, 32, meaning fetch-stage PC to predict.
REQ-006 SHALL have port pred_taken, output, 1, meaning predicted taken for if_pc.
REQ-007 SHALL have port pred_target, output, 32, meaning predicted target; if_pc+4 when pred_taken=0.
REQ-008 SHALL have port ex_valid, input, 1, meaning a resolving instruction is present this cycle.
REQ-009 SHALL have port ex_pc, input, 32, meaning PC of the resolving instruction.
REQ-010 SHALL have port ex_is_branch, input, 1, meaning the resolving instruction is a conditional branch.
REQ-011 SHALL have port ex_taken, input, 1, meaning resolved outcome (branch comparator result).
REQ-012 SHALL have port ex_target, input, 32, meaning resolved branch target.
REQ-013 SHALL have port ex_pred_taken / ex_pred_target, input, 1/32, meaning the prediction carried down the pipeline with the instruction.
REQ-014 SHALL have port mispredict, output, 1, meaning flush-and-redirect request this cycle.
REQ-015 SHALL have port redirect_pc, output, 32, meaning correct next PC when mispredict=1, else don't-care.
REQ-016 SHALL have ports branch_cnt and miss_cnt, output, 32 each, meaning resolved-branch count and mispredict count.

Function
REQ-017 Each entry SHALL hold valid, tag = PC[31:IDXW+2], target[31:0], and a 2-bit saturating counter.
REQ-018 Prediction SHALL be combinational: hit = valid && tag match; pred_taken = hit && counter[1]; pred_target = pred_taken ? entry target : if_pc+4.
REQ-019 mispredict SHALL be combinational, asserted iff ex_valid and one of: (a) ex_is_branch and ex_taken != ex_pred_taken; (b) ex_is_branch and ex_taken and ex_pred_target != ex_target; (c) !ex_is_branch and ex_pred_taken.
REQ-020 redirect_pc SHALL be ex_target when ex_is_branch && ex_taken, else ex_pc+4 (32-bit wrap, no carry out).
REQ-021 Table update SHALL occur at the clk edge only when ex_valid; 1-cycle update latency.
REQ-022 Branch hit: counter +1 if ex_taken (saturate at 11), -1 if not (saturate at 00); target <= ex_target if ex_taken.
REQ-023 Branch miss, taken: allocate (valid=1, tag, target=ex_target, counter=10), overwriting the occupant.
REQ-024 Branch miss, not taken: no table write.
REQ-025 Non-branch hit (aliasing, case c): entry valid <= 0.
REQ-026 Same-index read and write in one cycle: prediction SHALL use the pre-write contents (no bypass).
REQ-027 branch_cnt SHALL increment on each ex_valid && ex_is_branch; miss_cnt on each mispredict; both wrap at 2^32.
REQ-028 ex_* inputs SHALL be ignored when ex_valid=0; mispredict=0 then.

Reset
REQ-029 On reset, all valid bits, counters, branch_cnt and miss_cnt SHALL clear to 0 at the next clk edge; pred_taken=0, mispredict=0 (given ex_valid=0).
REQ-030 Reset SHALL take priority over a simultaneous update; a branch resolving during reset is neither counted nor written.
REQ-031 Target and tag fields need not be reset.

Structure
REQ-032 Shared package SHALL hold counter encodings SNT=00, WNT=01, WT=10, ST=11, the allocation value WT, and ENTRIES/IDXW defaults.
REQ-033 One sub-module, bp_sat_counter (2-bit saturating next-state from current state and taken), SHALL be used.

Verification
REQ-034 After reset, if_pc=0x00400010 -> pred_taken=0, pred_target=0x00400014; branch_cnt=miss_cnt=0.
REQ-035 Resolve ex_pc=0x00400010, taken, target 0x00400040, pred 0 -> mispredict=1, redirect_pc=0x00400040; next cycle if_pc=0x00400010 -> pred_taken=1, pred_target=0x00400040.
REQ-036 Same branch resolved not-taken twice from counter 10 -> first resolve redirects to 0x00400014 with counter 01 after it; second resolve (pred 0) gives no mispredict, counter 00, pred_taken=0.
REQ-037 Alias: non-branch ex_pc=0x00400050 (same index as 0x00400010 for ENTRIES=16) with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x00400054, entry invalidated.
REQ-038 Resolve and fetch same index same cycle -> pred_* reflect old entry; updated value visible next cycle.
REQ-039 Assert reset while ex_valid=1 with a taken branch -> no allocation, counters stay 0.
